uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 6 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 95 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared defaults and arbiter state type for the UART transmit arbiter.
package uart_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int NUM_REQ_DEF = 4;
  typedef enum logic {IDLE, LOCKED} arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting one past last_ptr_i.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] last_ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);
  localparam int IW = $clog2(N);
  int k;
  logic [IW-1:0] j;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k = 0;
    j = '0;
    for (int i = 1; i <= N; i++) begin
      k = (int'(last_ptr_i) + i) % N;
      j = IW'(k);
      if (!any_o && req_i[j]) begin
        any_o = 1'b1;
        idx_o = j;
        gnt_o[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin byte arbiter feeding a first-word-fall-through register to a UART transmitter.
// Define UART_ARB_PACKET_LOCK_EN to hold the grant on one requester until its req_last byte.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [DATA_W-1:0]          dout,
  output logic                       empty,
  input  logic                       re,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       locked
);
  localparam int IW = $clog2(NUM_REQ);
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [IW-1:0]       out_id_q, out_id_d, last_ptr_q, last_ptr_d, win_idx;
  logic [NUM_REQ-1:0]  eligible, win_gnt;
  logic [DATA_W-1:0]   req_bytes [NUM_REQ];
  logic                win_any, load, accept;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_bytes[g] = req_data[g*DATA_W +: DATA_W];
  end

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i      (eligible),
    .last_ptr_i (last_ptr_q),
    .gnt_o      (win_gnt),
    .idx_o      (win_idx),
    .any_o      (win_any)
  );

  // rst gating keeps req_ready low while reset is held even though the register reads empty
  assign load      = !out_valid_q || re;
  assign accept    = rst && load && win_any;
  assign req_ready = accept ? win_gnt : '0;
  assign dout      = out_data_q;
  assign empty     = !out_valid_q;
  assign grant_id  = out_id_q;

  always_comb begin
    out_valid_d = accept || (out_valid_q && !re);
    out_data_d  = accept ? req_bytes[win_idx] : out_data_q;
    out_id_d    = accept ? win_idx : out_id_q;
    last_ptr_d  = accept ? win_idx : last_ptr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      last_ptr_q  <= IW'(NUM_REQ - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      last_ptr_q  <= last_ptr_d;
    end
  end

`ifdef UART_ARB_PACKET_LOCK_EN
  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] owner_q, owner_d;
  assign eligible = (state_q == LOCKED) ? (req_valid & owner_q) : req_valid;
  assign locked   = state_q == LOCKED;
  // every accepted byte re-evaluates the lock from its own last flag
  always_comb begin
    state_d = accept ? (req_last[win_idx] ? IDLE : LOCKED) : state_q;
    owner_d = accept ? win_gnt : owner_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign eligible    = req_valid;
  assign locked      = 1'b0;
`endif
endmodule
